// File: rtl/arb_pkg.sv
// Shared types for the N-way arbiter.
// Mode and state enums plus a one-hot mask helper.
package arb_pkg;

   localparam int MAX_N = 32;

   typedef enum logic {
      ARB_FIXED = 1'b0,
      ARB_RR    = 1'b1
   } arb_mode_e;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_e;

   function automatic logic [MAX_N-1:0] idx_mask(
      input logic [31:0] idx
   );
      return MAX_N'(1) << idx;
   endfunction

endpackage

// File: rtl/arb_n_rr_pick.sv
// Combinational winner search: rotate so start_idx is bit 0,
// take the lowest set bit, then rotate the index back.
module arb_pick #(
   parameter int N     = 4,
   parameter int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     req_masked,
   input  logic [IDX_W-1:0] start_idx,
   output logic             found,
   output logic [IDX_W-1:0] pick_idx
);

   localparam logic [IDX_W:0] SPAN = (IDX_W+1)'(N);

   logic [2*N-1:0]   dbl;
   logic [N-1:0]     rot;
   logic [IDX_W-1:0] low;
   logic [IDX_W:0]   sum;

   always_comb begin
      dbl = {req_masked, req_masked};
      rot = N'(dbl >> start_idx);
      found = |rot;
      low = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (rot[i]) low = IDX_W'(i);
      end
      sum = {1'b0, low} + {1'b0, start_idx};
      if (sum >= SPAN) sum = sum - SPAN;
      pick_idx = sum[IDX_W-1:0];
   end

endmodule

// File: rtl/arb_n_rr.sv
// N-requester arbiter, fixed or round-robin, registered one-hot
// grant with an optional hold limit that forces re-arbitration.
module arb_n_rr
   import arb_pkg::*;
#(
   parameter int N        = 4,
   parameter int MAX_HOLD = 0,
   parameter int IDX_W    = $clog2(N)
) (
   input  logic             clk,
   input  logic             reset,
   input  arb_mode_e        mode,
   input  logic [N-1:0]     req,
   output logic [N-1:0]     grant,
   output logic             grant_valid,
   output logic [IDX_W-1:0] grant_idx,
   output logic             hold_expired
);

   localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

   arb_state_e       state_q;
   arb_state_e       state_d;
   logic [IDX_W-1:0] ptr_q;
   logic [IDX_W-1:0] ptr_d;
   logic [N-1:0]     grant_d;
   logic [IDX_W-1:0] idx_d;
   logic             exp_d;

   logic             held;
   logic             at_limit;
   logic             expired;
   logic [N-1:0]     cur_mask;
   logic [N-1:0]     masked;
   logic [IDX_W-1:0] start;
   logic             found;
   logic [IDX_W-1:0] pick_idx;

   logic take;
   logic regrant;
   logic drop;
   logic cnt_clr;
   logic cnt_inc;

   always_comb begin
      held     = req[grant_idx];
      expired  = (state_q == BUSY) && held && at_limit;
      cur_mask = N'(idx_mask(32'(grant_idx)));
      masked   = expired ? (req & ~cur_mask) : req;
      start    = '0;
      if (mode == ARB_RR) begin
         start = (ptr_q == LAST) ? '0 : ptr_q + IDX_W'(1);
      end
   end

   // Single search shared by the idle, release and expiry paths
   arb_pick #(
      .N     (N),
      .IDX_W (IDX_W)
   ) u_pick (
      .req_masked (masked),
      .start_idx  (start),
      .found      (found),
      .pick_idx   (pick_idx)
   );

   always_comb begin
      take    = 1'b0;
      regrant = 1'b0;
      drop    = 1'b0;
      cnt_inc = 1'b0;
      exp_d   = 1'b0;
      unique case (state_q)
         IDLE: take = found;
         BUSY: begin
            unique case (1'b1)
               expired: begin
                  take    = found;
                  regrant = !found;
                  exp_d   = found;
               end
               held && !at_limit: cnt_inc = 1'b1;
               !held: begin
                  take = found;
                  drop = !found;
               end
            endcase
         end
      endcase
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant;
      idx_d   = grant_idx;
      ptr_d   = ptr_q;
      cnt_clr = 1'b0;
      if (take) begin
         state_d = BUSY;
         grant_d = N'(idx_mask(32'(pick_idx)));
         idx_d   = pick_idx;
         ptr_d   = pick_idx;
         cnt_clr = 1'b1;
      end
      if (regrant) begin
         ptr_d   = grant_idx;
         cnt_clr = 1'b1;
      end
      if (drop) begin
         state_d = IDLE;
         grant_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         grant        <= '0;
         grant_valid  <= 1'b0;
         grant_idx    <= '0;
         hold_expired <= 1'b0;
         ptr_q        <= LAST;
      end else begin
         state_q      <= state_d;
         grant        <= grant_d;
         grant_valid  <= |grant_d;
         grant_idx    <= idx_d;
         hold_expired <= exp_d;
         ptr_q        <= ptr_d;
      end
   end

   generate
      if (MAX_HOLD > 0) begin : g_hold
         localparam int CW = $clog2(MAX_HOLD + 1);
         logic [CW-1:0] cnt_q;

         always_ff @(posedge clk) begin
            if (reset || cnt_clr) begin
               cnt_q <= '0;
            end else if (cnt_inc) begin
               cnt_q <= cnt_q + CW'(1);
            end
         end

         assign at_limit = (cnt_q == CW'(MAX_HOLD - 1));
      end else begin : g_nohold
         logic unused_cnt;
         assign unused_cnt = cnt_clr ^ cnt_inc;
         assign at_limit   = 1'b0;
      end
   endgenerate

endmodule

// File: tb/tb_arb_n_rr.sv
// Directed bench: vector table on a MAX_HOLD=3 instance,
// round-robin rotation on a MAX_HOLD=1 instance.
module tb_arb_n_rr;
   import arb_pkg::*;

   typedef struct {
      logic      rst;
      arb_mode_e mode;
      logic [3:0] req;
      logic [3:0] grant;
      logic       hexp;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst3 = 1'b1;
   arb_mode_e  mode3 = ARB_FIXED;
   logic [3:0] req3 = '0;
   logic [3:0] grant3;
   logic       gv3;
   logic [1:0] idx3;
   logic       hexp3;

   logic       rst1 = 1'b1;
   arb_mode_e  mode1 = ARB_FIXED;
   logic [3:0] req1 = '0;
   logic [3:0] grant1;
   logic       gv1;
   logic [1:0] idx1;
   logic       hexp1;

   int n_tests = 0;
   int n_fail  = 0;
   logic mon_on = 1'b0;

   always #5 clk = ~clk;

   arb_n_rr #(.N(4), .MAX_HOLD(3)) u3 (
      .clk          (clk),
      .reset        (rst3),
      .mode         (mode3),
      .req          (req3),
      .grant        (grant3),
      .grant_valid  (gv3),
      .grant_idx    (idx3),
      .hold_expired (hexp3)
   );

   arb_n_rr #(.N(4), .MAX_HOLD(1)) u1 (
      .clk          (clk),
      .reset        (rst1),
      .mode         (mode1),
      .req          (req1),
      .grant        (grant1),
      .grant_valid  (gv1),
      .grant_idx    (idx1),
      .hold_expired (hexp1)
   );

   task automatic chk(input string name, input int step,
                      input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s step %0d: got %0h want %0h",
                  name, step, act, exp);
      end
   endtask

   function automatic logic [1:0] oh2idx(input logic [3:0] g);
      logic [1:0] r = '0;
      for (int i = 0; i < 4; i++) if (g[i]) r = 2'(i);
      return r;
   endfunction

   function automatic vec_t mk(input logic r, input arb_mode_e m,
                               input logic [3:0] rq,
                               input logic [3:0] g, input logic h);
      vec_t v;
      v.rst = r; v.mode = m; v.req = rq; v.grant = g; v.hexp = h;
      return v;
   endfunction

   // Structural invariants on both instances every cycle
   always @(negedge clk) begin
      if (mon_on) begin
         chk("onehot3", 0, 32'($onehot0(grant3)), 32'd1);
         chk("valid3", 0, 32'(gv3), 32'(|grant3));
         if (gv3) chk("idx3", 0, 32'(grant3[idx3]), 32'd1);
         chk("onehot1", 0, 32'($onehot0(grant1)), 32'd1);
         chk("valid1", 0, 32'(gv1), 32'(|grant1));
         if (gv1) chk("idx1", 0, 32'(grant1[idx1]), 32'd1);
      end
   end

   initial begin
      vec_t vecs[$];
      logic [3:0] rr_exp[5];
      logic       rr_hx[5];
      logic [1:0] eidx = '0;

      vecs.push_back(mk(1, ARB_FIXED, 4'b0000, 4'b0000, 0));
      vecs.push_back(mk(1, ARB_FIXED, 4'b0101, 4'b0000, 0));
      vecs.push_back(mk(0, ARB_FIXED, 4'b0101, 4'b0001, 0));
      vecs.push_back(mk(0, ARB_FIXED, 4'b0100, 4'b0100, 0));
      vecs.push_back(mk(0, ARB_FIXED, 4'b0000, 4'b0000, 0));
      vecs.push_back(mk(0, ARB_FIXED, 4'b0100, 4'b0100, 0));
      vecs.push_back(mk(0, ARB_FIXED, 4'b0101, 4'b0100, 0));
      vecs.push_back(mk(0, ARB_FIXED, 4'b0101, 4'b0100, 0));
      vecs.push_back(mk(0, ARB_FIXED, 4'b0001, 4'b0001, 0));
      vecs.push_back(mk(0, ARB_FIXED, 4'b0000, 4'b0000, 0));
      vecs.push_back(mk(0, ARB_FIXED, 4'b0011, 4'b0001, 0));
      vecs.push_back(mk(0, ARB_FIXED, 4'b0011, 4'b0001, 0));
      vecs.push_back(mk(0, ARB_FIXED, 4'b0011, 4'b0001, 0));
      vecs.push_back(mk(0, ARB_FIXED, 4'b0011, 4'b0010, 1));
      vecs.push_back(mk(0, ARB_FIXED, 4'b0011, 4'b0010, 0));
      vecs.push_back(mk(0, ARB_FIXED, 4'b0011, 4'b0010, 0));
      vecs.push_back(mk(0, ARB_FIXED, 4'b0011, 4'b0001, 1));
      vecs.push_back(mk(0, ARB_FIXED, 4'b0000, 4'b0000, 0));
      for (int i = 0; i < 7; i++)
         vecs.push_back(mk(0, ARB_FIXED, 4'b1000, 4'b1000, 0));
      vecs.push_back(mk(0, ARB_FIXED, 4'b0000, 4'b0000, 0));
      vecs.push_back(mk(0, ARB_FIXED, 4'b0010, 4'b0010, 0));
      vecs.push_back(mk(1, ARB_FIXED, 4'b0010, 4'b0000, 0));
      vecs.push_back(mk(0, ARB_RR,    4'b1111, 4'b0001, 0));
      vecs.push_back(mk(0, ARB_RR,    4'b1111, 4'b0001, 0));
      vecs.push_back(mk(0, ARB_RR,    4'b1111, 4'b0001, 0));
      vecs.push_back(mk(0, ARB_RR,    4'b1111, 4'b0010, 1));
      vecs.push_back(mk(0, ARB_RR,    4'b0000, 4'b0000, 0));
      vecs.push_back(mk(0, ARB_RR,    4'b1001, 4'b1000, 0));
      vecs.push_back(mk(0, ARB_RR,    4'b0001, 4'b0001, 0));
      vecs.push_back(mk(0, ARB_FIXED, 4'b1010, 4'b0010, 0));
      vecs.push_back(mk(0, ARB_FIXED, 4'b0000, 4'b0000, 0));

      rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      rr_hx  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

      foreach (vecs[i]) begin
         rst3  = vecs[i].rst;
         mode3 = vecs[i].mode;
         req3  = vecs[i].req;
         @(posedge clk);
         #1;
         mon_on = 1'b1;
         if (vecs[i].rst) eidx = '0;
         else if (vecs[i].grant != '0) eidx = oh2idx(vecs[i].grant);
         chk("grant", i, 32'(grant3), 32'(vecs[i].grant));
         chk("grant_valid", i, 32'(gv3), 32'(vecs[i].grant != '0));
         chk("hold_expired", i, 32'(hexp3), 32'(vecs[i].hexp));
         chk("grant_idx", i, 32'(idx3), 32'(eidx));
      end

      chk("rr_reset_grant", 0, 32'(grant1), 32'd0);
      rst1  = 1'b0;
      mode1 = ARB_RR;
      req1  = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         chk("rr_grant", i, 32'(grant1), 32'(rr_exp[i]));
         chk("rr_hold_expired", i, 32'(hexp1), 32'(rr_hx[i]));
         chk("rr_idx", i, 32'(idx1), 32'(oh2idx(rr_exp[i])));
      end

      req1 = '0;
      @(posedge clk);
      #1;
      chk("rr_idle", 0, 32'(gv1), 32'd0);
      chk("rr_idx_hold", 0, 32'(idx1), 32'd0);

      mon_on = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
